// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// Produces a divided pixel-enable tick, pixel coordinates, sync pulses of selectable
// polarity, video_on and aligned line/frame start strobes.
// Optional build macro VGA_TIMING_GEN_FRAME_CNT_EN adds the FC_W parameter and the
// frame_count output (frames completed, wrapping).
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          H_POL    = 1'b1,
    parameter bit          V_POL    = 1'b1,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 10
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    ,
    parameter int unsigned FC_W     = 8
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    output logic            p_tick,
    output logic [X_W-1:0]  pixel_x,
    output logic [Y_W-1:0]  pixel_y,
    output logic            hsync,
    output logic            vsync,
    output logic            video_on,
    output logic            line_start,
    output logic            frame_start
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    ,
    output logic [FC_W-1:0] frame_count
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] H_VIS    = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] HS_FIRST = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HS_LAST  = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);

    localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] V_VIS    = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] VS_FIRST = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VS_LAST  = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [X_W-1:0]   h_count_q, h_count_d;
    logic [Y_W-1:0]   v_count_q, v_count_d;
    logic             h_wrap, v_wrap;

    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic video_on_q, video_on_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;

    assign h_wrap = (h_count_q == H_LAST);
    assign v_wrap = (v_count_q == V_LAST);

    // Pixel-enable strobe on the last clk of each divide period; forced low in reset
    always_comb begin
        p_tick = 1'b0;
        if (en && !reset && (div_cnt_q == DIV_LAST)) begin
            p_tick = 1'b1;
        end
    end

    // Divider next state: advance only while running, wrap after CLK_DIV clks
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (en) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    // Raster counters next state: x on every tick, y only when x wraps
    always_comb begin
        h_count_d = h_count_q;
        v_count_d = v_count_q;
        if (p_tick) begin
            if (h_wrap) begin
                h_count_d = '0;
                if (v_wrap) begin
                    v_count_d = '0;
                end else begin
                    v_count_d = v_count_q + 1'b1;
                end
            end else begin
                h_count_d = h_count_q + 1'b1;
            end
        end
    end

    // Decode from the next counts so registered outputs line up with pixel_x/pixel_y
    always_comb begin
        hsync_d       = ~H_POL;
        vsync_d       = ~V_POL;
        video_on_d    = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if ((h_count_d >= HS_FIRST) && (h_count_d <= HS_LAST)) begin
            hsync_d = H_POL;
        end
        if ((v_count_d >= VS_FIRST) && (v_count_d <= VS_LAST)) begin
            vsync_d = V_POL;
        end
        if ((h_count_d < H_VIS) && (v_count_d < V_VIS)) begin
            video_on_d = 1'b1;
        end
        if (p_tick && h_wrap) begin
            line_start_d = 1'b1;
            if (v_wrap) begin
                frame_start_d = 1'b1;
            end
        end
    end

    // Timing state: divider and raster counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            h_count_q <= '0;
            v_count_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_count_q <= h_count_d;
            v_count_q <= v_count_d;
        end
    end

    // Registered outputs; frozen while en is low so a paused raster keeps its strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            video_on_q    <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (en) begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    logic [FC_W-1:0] frame_count_q;

    // Count frames on the same edge that raises frame_start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count_q <= '0;
        end else if (frame_start_d) begin
            frame_count_q <= frame_count_q + 1'b1;
        end
    end

    assign frame_count = frame_count_q;
`endif

    assign pixel_x     = h_count_q;
    assign pixel_y     = v_count_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised raster timing generator; the successor to the FallingCubes fixed 640x480 sync block.
- Produces hsync/vsync, video_on, a pixel-enable tick, pixel coordinates, and line/frame start strobes for any mode set by parameters.
- Adds a programmable clock divider, selectable sync polarity, a run enable and aligned start-of-line/frame pulses.
- Sits between the board clock and the pixel/graphics generators feeding the VGA DAC pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels after active, before sync)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch (after sync, before next active)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 1, hsync asserted level (1 = active-high, 0 = active-low)
- V_POL, 1, vsync asserted level
- CLK_DIV, 4, clk cycles per pixel; legal range 1..256
- X_W, 10, pixel_x width; must hold H_TOTAL-1
- Y_W, 10, pixel_y width; must hold V_TOTAL-1
- FC_W, 8, frame_count width (optional feature only)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  run enable; low freezes all timing state
- p_tick  out  1  one-clk pixel-enable strobe
- pixel_x  out  X_W  horizontal count, 0..H_TOTAL-1
- pixel_y  out  Y_W  vertical count, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity H_POL
- vsync  out  1  vertical sync, polarity V_POL
- video_on  out  1  high when pixel_x<H_ACTIVE and pixel_y<V_ACTIVE
- line_start  out  1  one-clk pulse when pixel_x wraps to 0
- frame_start  out  1  one-clk pulse when pixel_x and pixel_y both wrap to 0
- frame_count  out  FC_W  frames completed (present only with the optional feature)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Divider: div_cnt runs 0..CLK_DIV-1 and advances only when en=1.
  - p_tick=1 (combinational) exactly when en=1 and div_cnt==CLK_DIV-1.
  - With CLK_DIV=1, p_tick equals en.
- On each p_tick, h_count increments; at H_TOTAL-1 it wraps to 0.
- v_count increments only on a p_tick where h_count wraps; at V_TOTAL-1 it wraps to 0.
- pixel_x and pixel_y are the count registers themselves.
- hsync, vsync, video_on, line_start and frame_start are registered. They are computed from the next-count values, so on any clk they describe the same pixel as pixel_x/pixel_y (zero skew, no extra latency).
  - hsync = H_POL when h_count is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (default 656..751); otherwise ~H_POL.
  - vsync = V_POL when v_count is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (default 490..491); otherwise ~V_POL.
  - line_start is high for exactly the one clk after the edge that loads h_count=0, then low until the next wrap.
  - frame_start is the same, additionally requiring v_count=0.
- Reset (asynchronous, any time, including mid-line):
  - div_cnt=0, pixel_x=0, pixel_y=0.
  - hsync=~H_POL, vsync=~V_POL, video_on=1, line_start=0, frame_start=0, frame_count=0.
  - p_tick=0 while reset is high.
- After reset release with en=1, the first p_tick occurs in the CLK_DIV-th clk cycle.
- No line_start/frame_start is emitted for the reset position (0,0); the first strobes come at the first wrap.
- en=0: div_cnt, counts and all registered outputs hold; p_tick=0. On en returning high, timing resumes from the held div_cnt (no skipped or doubled pixel).
- Timing always starts at (0,0) after reset; there is no mid-frame resynchronisation input.

Optional Feature:
- Macro: VGA_TIMING_GEN_FRAME_CNT_EN.
- Defined: frame_count port exists. It increments by 1 on every clk where frame_start goes high, wraps at 2^FC_W-1 -> 0, and resets to 0.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Defaults, en=1, run 2 frames -> p_tick every 4th clk; 420000 p_ticks per frame; frame_start spacing 1680000 clks; line_start spacing 3200 clks.
- Defaults -> hsync high exactly for pixel_x 656..751; vsync high exactly for pixel_y 490..491; video_on low at pixel_x=640 and at pixel_y=480, high at (639,479).
- H_POL=0, V_POL=0, CLK_DIV=1, tiny mode (H 8/2/2/2, V 4/1/1/1) -> hsync low only at x=10..11; p_tick constant high; frame every 98 clks.
- Drop en for 7 clks at pixel_x=100, mid-divide -> counts and div_cnt frozen, p_tick=0; pixel_x=101 exactly 4 enabled clks after the last tick.
- Assert reset asynchronously at (700,300) between clk edges -> outputs reach reset values immediately; after release the first p_tick comes on the 4th clk and pixel_x=1.
- With VGA_TIMING_GEN_FRAME_CNT_EN, FC_W=2, tiny mode -> frame_count goes 1,2,3,0 over 4 frames; without the macro, the build elaborates with no frame_count port.
